mat2x2_operand_loader: RTL and testbench
========================================

// Module: mat2x2_operand_loader
// PURPOSE
//  Upstream feeder for the 2x2 matrix multiplier FSM. Accepts the eight signed operands
//  of one product (A=[a b;c d], B=[e f;g h]) as a serial valid/ready stream. Presents them
//  in parallel on a..h, issues a one-cycle start and holds the operands stable until the
//  multiplier reports done. Flags malformed frames and a multiplier that never completes.
// PARAMETERS
//  DW       16  operand width (signed); must match multiplier input width
//  TMO_CYC   8  max cycles in WAIT without done before timeout (>=4; multiplier needs 3)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset_n        in   1   one clock; reset is asynchronous and active-low
//  s_valid        in   1   upstream operand valid
//  s_ready        out  1   loader accepts operand this cycle
//  s_data         in   DW  signed operand; frame order a,b,c,d,e,f,g,h
//  s_last         in   1   marks 8th (h) element of a frame
//  a,b,c,d,e,f,g,h out DW  operand registers to multiplier, one port each
//  start          out  1   one-cycle pulse to multiplier
//  done           in   1   multiplier completion
//  busy           out  1   high when not in LOAD
//  err_len        out  1   one-cycle pulse: frame length error, frame dropped
//  err_tmo        out  1   one-cycle pulse: done not seen within TMO_CYC
// BEHAVIOUR
//  Reset (async, reset_n=0): state=LOAD, idx=0, tmo_cnt=0; a..h=0; start=0, err_len=0,
//   err_tmo=0, busy=0. All outputs take reset values immediately; a partial frame is lost.
//  Handshake: transfer when s_valid && s_ready. s_ready=(state==LOAD) && reset_n.
//   s_data/s_last are ignored when no transfer occurs.
//  idx: 3-bit element counter. A transfer writes s_data into operand[idx] (0=a .. 7=h).
//  LOAD:
//   - transfer with idx<7, s_last=0 -> idx+1.
//   - transfer with idx<7, s_last=1 -> err_len pulse, idx=0, stay LOAD (short frame).
//   - transfer with idx==7, s_last=0 -> err_len pulse, idx=0, stay LOAD (long frame).
//   - transfer with idx==7, s_last=1 -> idx=0, go ISSUE.
//   - Dropped frames never raise start. Operand regs may hold partial data; the multiplier
//     ignores them because it samples only on start.
//  ISSUE (1 cycle): start=1, s_ready=0, go WAIT, tmo_cnt=0.
//  WAIT: s_ready=0, tmo_cnt+1 per cycle.
//   - done=1 -> go LOAD; s_ready is high the next cycle.
//   - tmo_cnt==TMO_CYC-1 and done=0 -> err_tmo pulse, go LOAD.
//   - done and timeout in the same cycle: done wins, no err_tmo.
//  a..h are written only in LOAD. They are stable from the cycle after the h transfer
//   through the end of WAIT.
//  done in LOAD/ISSUE is ignored. start and err_* are registered and never high together.
//  Latency: the h transfer is at edge N, so start is high in cycle N+1. The multiplier
//   asserts done 3 cycles after the start cycle, and the loader accepts the next 'a' in
//   the cycle after done.
//  Widths: operands pass through unmodified (no extension or truncation; sign preserved).
//   tmo_cnt width is $clog2(TMO_CYC+1).
// TESTING
//  T1 frame 1,2,3,4,5,6,7,8 (s_last on 8) -> a..h=1..8, single start pulse the cycle after
//     the 8th transfer; with the real multiplier attached w=19, x=22, y=43, z=50,
//     s_ready=1 the cycle after done.
//  T2 frame with a=16'h8000, h=16'h7FFF, random s_valid gaps -> outputs bit-exact,
//     no transfers lost or duplicated, start still a single pulse.
//  T3 s_last on the 5th element, then a valid frame -> err_len one pulse, no start, idx
//     restarts; second frame loads correctly and issues start.
//  T4 done held 0 after start, TMO_CYC=8 -> err_tmo pulses 8 cycles after ISSUE,
//     busy falls, s_ready=1.
//  T5 reset_n=0 in mid-WAIT -> start, busy and err_* at 0 and a..h=0 without waiting for
//     a clock edge; after release a new frame is accepted from element a.
//  T6 s_valid=1 during ISSUE/WAIT -> no transfer (s_ready=0), a..h unchanged; done and
//     timeout in the same cycle -> no err_tmo.

Source files
------------

// File: rtl/mat2x2_operand_loader.sv
// ---------------------------------------------------------------------------
// mat2x2_operand_loader
//
// Upstream feeder for the 2x2 matrix multiplier. Collects the eight signed
// operands of one product (A=[a b;c d], B=[e f;g h]) from a serial
// valid/ready stream and presents them in parallel. Once a frame is complete
// it issues a one-cycle start pulse and holds the operands stable until the
// multiplier reports done. Frames of the wrong length and a multiplier that
// never completes are flagged with one-cycle error pulses.
//
// Parameters
//   DW       operand width (signed), must match the multiplier input width
//   TMO_CYC  cycles allowed in WAIT without done before a timeout (>= 4)
//
// Ports
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   s_valid      upstream operand valid
//   s_ready      loader accepts an operand this cycle
//   s_data       signed operand, frame order a,b,c,d,e,f,g,h
//   s_last       marks the 8th (h) element of a frame
//   a..h         operand registers driving the multiplier
//   start        one-cycle pulse to the multiplier
//   done         multiplier completion
//   busy         high whenever the loader is not in LOAD
//   err_len      one-cycle pulse: short or long frame, frame dropped
//   err_tmo      one-cycle pulse: done not seen within TMO_CYC cycles
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mat2x2_operand_loader #(
    parameter int DW      = 16,
    parameter int TMO_CYC = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_last,
    output logic signed [DW-1:0] a,
    output logic signed [DW-1:0] b,
    output logic signed [DW-1:0] c,
    output logic signed [DW-1:0] d,
    output logic signed [DW-1:0] e,
    output logic signed [DW-1:0] f,
    output logic signed [DW-1:0] g,
    output logic signed [DW-1:0] h,
    output logic                 start,
    input  logic                 done,
    output logic                 busy,
    output logic                 err_len,
    output logic                 err_tmo
);

    localparam int             CW       = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_idx;
    logic [CW-1:0]        r_tmoCnt;
    logic signed [DW-1:0] r_op [8];
    logic                 r_start;
    logic                 r_errLen;
    logic                 r_errTmo;
    logic                 w_xfer;

    // Ready is gated by reset_n so nothing is accepted while reset is held,
    // even though the state register already reads LOAD.
    assign s_ready = (r_state == ST_LOAD) && reset_n;
    assign w_xfer  = s_valid && s_ready;
    assign busy    = (r_state != ST_LOAD);

    assign start   = r_start;
    assign err_len = r_errLen;
    assign err_tmo = r_errTmo;

    assign a = r_op[0];
    assign b = r_op[1];
    assign c = r_op[2];
    assign d = r_op[3];
    assign e = r_op[4];
    assign f = r_op[5];
    assign g = r_op[6];
    assign h = r_op[7];

    // Main controller. LOAD gathers operands by index, ISSUE fires start for
    // exactly one cycle, WAIT counts toward the timeout until done arrives.
    // Operand registers are only written on a LOAD transfer, so they stay
    // frozen through ISSUE and WAIT. A dropped frame may leave partial data
    // behind; that is harmless because the multiplier samples only on start.
    // Pulse outputs default low each cycle so they can never stretch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_LOAD;
            r_idx    <= '0;
            r_tmoCnt <= '0;
            r_start  <= 1'b0;
            r_errLen <= 1'b0;
            r_errTmo <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_op[i] <= '0;
            end
        end else begin
            r_start  <= 1'b0;
            r_errLen <= 1'b0;
            r_errTmo <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_op[r_idx] <= s_data;
                        if ((r_idx == 3'd7) && s_last) begin
                            r_idx   <= '0;
                            r_start <= 1'b1;
                            r_state <= ST_ISSUE;
                        end else if ((r_idx == 3'd7) || s_last) begin
                            // short frame (early last) or long frame (no last on h)
                            r_idx    <= '0;
                            r_errLen <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_tmoCnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_tmoCnt <= r_tmoCnt + CW'(1);
                    // done takes priority over a timeout in the same cycle
                    if (done) begin
                        r_state <= ST_LOAD;
                    end else if (r_tmoCnt == TMO_LAST) begin
                        r_errTmo <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat2x2_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_mat2x2_operand_loader
//
// Self-checking bench for mat2x2_operand_loader. A behavioural model tracks
// the current frame as a queue of received operands and the wait as a plain
// cycle count; its expectations are compared with the DUT every cycle. A
// hand-derived vector table covers the basic frame / short-frame flow, and
// hand-written sequences cover boundary values, timeout, async reset and
// done-versus-timeout priority, followed by a randomized run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mat2x2_operand_loader;

    localparam int DW      = 16;
    localparam int TMO_CYC = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 s_last;
    logic signed [DW-1:0] a, b, c, d, e, f, g, h;
    logic                 start;
    logic                 done;
    logic                 busy;
    logic                 err_len;
    logic                 err_tmo;

    logic signed [DW-1:0] dutOps [8];

    assign dutOps[0] = a;
    assign dutOps[1] = b;
    assign dutOps[2] = c;
    assign dutOps[3] = d;
    assign dutOps[4] = e;
    assign dutOps[5] = f;
    assign dutOps[6] = g;
    assign dutOps[7] = h;

    always #5 clk = ~clk;

    mat2x2_operand_loader #(
        .DW      (DW),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g),
        .h       (h),
        .start   (start),
        .done    (done),
        .busy    (busy),
        .err_len (err_len),
        .err_tmo (err_tmo)
    );

    int checks   = 0;
    int failures = 0;

    string opNames [8] = '{"a", "b", "c", "d", "e", "f", "g", "h"};

    // Behavioural model: which phase we are in, the operands received so far
    // in the current frame, the visible operand values, and the pulse flags
    // that should be visible during the current cycle.
    typedef enum int {M_LOAD, M_ISSUE, M_WAIT} mode_t;

    mode_t                mMode;
    logic signed [DW-1:0] mOps [8];
    logic signed [DW-1:0] frameQ [$];
    int                   mWait;
    bit                   mStart;
    bit                   mErrLen;
    bit                   mErrTmo;

    typedef struct {
        bit          v;
        logic [15:0] dat;
        bit          l;
        bit          dn;
        bit          expReady;
        bit          expBusy;
        bit          expStart;
        bit          expErrLen;
    } vec_t;

    vec_t tbl [$];

    task automatic checkVal(input string name, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode = M_LOAD;
        for (int i = 0; i < 8; i++) mOps[i] = '0;
        frameQ.delete();
        mWait   = 0;
        mStart  = 1'b0;
        mErrLen = 1'b0;
        mErrTmo = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic modelStep();
        bit nStart;
        bit nErrLen;
        bit nErrTmo;
        nStart  = 1'b0;
        nErrLen = 1'b0;
        nErrTmo = 1'b0;
        if (!reset_n) begin
            modelReset();
            return;
        end
        case (mMode)
            M_LOAD: begin
                if (s_valid) begin
                    mOps[frameQ.size()] = s_data;
                    frameQ.push_back(s_data);
                    if (s_last || frameQ.size() == 8) begin
                        if (s_last && frameQ.size() == 8) begin
                            mMode  = M_ISSUE;
                            nStart = 1'b1;
                        end else begin
                            nErrLen = 1'b1;
                        end
                        frameQ.delete();
                    end
                end
            end
            M_ISSUE: begin
                mMode = M_WAIT;
                mWait = 0;
            end
            M_WAIT: begin
                mWait++;
                if (done) begin
                    mMode = M_LOAD;
                end else if (mWait == TMO_CYC) begin
                    nErrTmo = 1'b1;
                    mMode   = M_LOAD;
                end
            end
            default: mMode = M_LOAD;
        endcase
        mStart  = nStart;
        mErrLen = nErrLen;
        mErrTmo = nErrTmo;
    endtask

    task automatic checkOutput();
        checkVal("s_ready", s_ready, (mMode == M_LOAD) && reset_n);
        checkVal("busy", busy, mMode != M_LOAD);
        checkVal("start", start, mStart);
        checkVal("err_len", err_len, mErrLen);
        checkVal("err_tmo", err_tmo, mErrTmo);
        for (int i = 0; i < 8; i++) begin
            checkVal({"op_", opNames[i]}, dutOps[i], mOps[i]);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [15:0] dat,
                                 input bit l, input bit dn);
        s_valid = v;
        s_data  = dat;
        s_last  = l;
        done    = dn;
    endtask

    // One clock: drive, check mid-cycle, advance model, step to just after the edge.
    task automatic runCycle(input bit v, input logic [15:0] dat,
                            input bit l, input bit dn);
        applyStimulus(v, dat, l, dn);
        @(negedge clk);
        checkOutput();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input int base);
        for (int i = 0; i < 8; i++) begin
            runCycle(1'b1, 16'(base + i), i == 7, 1'b0);
        end
    endtask

    function automatic void addRow(input bit v, input int dat, input bit l, input bit dn,
                                   input bit er, input bit eb, input bit es, input bit eel);
        vec_t r;
        r.v         = v;
        r.dat       = 16'(dat);
        r.l         = l;
        r.dn        = dn;
        r.expReady  = er;
        r.expBusy   = eb;
        r.expStart  = es;
        r.expErrLen = eel;
        tbl.push_back(r);
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] t2Vals [8];
        int          t2Idx;
        int          guard;
        bit          rv;
        bit          rl;
        bit          rdn;
        logic [15:0] rd;
        logic signed [63:0] prod;

        // Frame 1..8 with a done three cycles after start, then a short frame
        // (last on the 5th element) followed by a valid frame 11..18.
        for (int i = 0; i < 8; i++) addRow(1, i + 1, i == 7, 0, 1, 0, 0, 0);
        addRow(1, 99, 0, 0, 0, 1, 1, 0);
        addRow(1, 77, 0, 0, 0, 1, 0, 0);
        addRow(0, 0, 0, 0, 0, 1, 0, 0);
        addRow(0, 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) addRow(1, 21 + i, i == 4, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) addRow(1, 11 + i, i == 7, 0, 1, 0, 0, i == 0);
        addRow(0, 0, 0, 0, 0, 1, 1, 0);
        addRow(0, 0, 0, 0, 0, 1, 0, 0);
        addRow(0, 0, 0, 0, 0, 1, 0, 0);
        addRow(0, 0, 0, 1, 0, 1, 0, 0);
        addRow(0, 0, 0, 0, 1, 0, 0, 0);

        // Reset state
        reset_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        reset_n = 1'b1;

        // Table-driven vectors
        for (int r = 0; r < tbl.size(); r++) begin
            applyStimulus(tbl[r].v, tbl[r].dat, tbl[r].l, tbl[r].dn);
            @(negedge clk);
            checkOutput();
            checkVal($sformatf("tbl%0d_ready", r), s_ready, tbl[r].expReady);
            checkVal($sformatf("tbl%0d_busy", r), busy, tbl[r].expBusy);
            checkVal($sformatf("tbl%0d_start", r), start, tbl[r].expStart);
            checkVal($sformatf("tbl%0d_err_len", r), err_len, tbl[r].expErrLen);
            if (r == 9) begin
                prod = 64'(a * e + b * g);
                checkVal("T1_w", prod, 19);
                prod = 64'(a * f + b * h);
                checkVal("T1_x", prod, 22);
                prod = 64'(c * e + d * g);
                checkVal("T1_y", prod, 43);
                prod = 64'(c * f + d * h);
                checkVal("T1_z", prod, 50);
            end
            modelStep();
            @(posedge clk);
            #1;
        end

        // T2: extreme values with random valid gaps
        t2Vals[0] = 16'h8000;
        for (int i = 1; i < 7; i++) t2Vals[i] = 16'($urandom);
        t2Vals[7] = 16'h7FFF;
        t2Idx = 0;
        guard = 0;
        while (t2Idx < 8 && guard < 200) begin
            rv = ($urandom % 3) != 0;
            if (rv) begin
                runCycle(1'b1, t2Vals[t2Idx], t2Idx == 7, 1'b0);
                t2Idx++;
            end else begin
                runCycle(1'b0, 16'($urandom), 1'b1, 1'b0);
            end
            guard++;
        end
        checkVal("T2_complete", t2Idx, 8);
        checkVal("T2_start", start, 1);
        checkVal("T2_a", a, -32768);
        checkVal("T2_h", h, 32767);
        for (int i = 0; i < 8; i++) begin
            checkVal({"T2_op_", opNames[i]}, dutOps[i], $signed(t2Vals[i]));
        end
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        runCycle(1'b0, 16'h0, 1'b0, 1'b1);

        // T4: timeout with done held low
        sendFrame(40);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < TMO_CYC; i++) runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        checkVal("T4_err_tmo", err_tmo, 1);
        checkVal("T4_busy", busy, 0);
        checkVal("T4_s_ready", s_ready, 1);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);

        // T6: valid held during ISSUE/WAIT, done arrives on the timeout cycle
        sendFrame(60);
        runCycle(1'b1, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < TMO_CYC - 1; i++) runCycle(1'b1, 16'h5555, 1'b1, 1'b0);
        runCycle(1'b1, 16'h6666, 1'b0, 1'b1);
        checkVal("T6_err_tmo", err_tmo, 0);
        checkVal("T6_s_ready", s_ready, 1);
        checkVal("T6_a", a, 60);
        checkVal("T6_h", h, 67);

        // T5: asynchronous reset in the middle of WAIT
        sendFrame(80);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        checkVal("T5_busy_before", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("T5_busy", busy, 0);
        checkVal("T5_start", start, 0);
        checkVal("T5_err_len", err_len, 0);
        checkVal("T5_err_tmo", err_tmo, 0);
        checkVal("T5_s_ready", s_ready, 0);
        for (int i = 0; i < 8; i++) checkVal({"T5_op_", opNames[i]}, dutOps[i], 0);
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sendFrame(100);
        checkVal("T5_a_after", a, 100);
        checkVal("T5_start_after", start, 1);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        runCycle(1'b0, 16'h0, 1'b0, 1'b0);
        runCycle(1'b0, 16'h0, 1'b0, 1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rv = ($urandom % 4) != 0;
            rd = 16'($urandom);
            if (frameQ.size() == 7) rl = ($urandom % 8) != 0;
            else                    rl = ($urandom % 20) == 0;
            if (mMode == M_WAIT) rdn = ($urandom % 3) == 0;
            else                 rdn = ($urandom % 6) == 0;
            runCycle(rv, rd, rl, rdn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
